// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single main-memory port between the instruction
// fetch refill path (port 0) and the data-cache refill/write-through path
// (port 1). One transaction is in flight at a time. The winning request is
// latched, so the requester may change its inputs while memory is working.
// Optional feature macro: MEM_ARB_RR_EN selects round-robin tie breaking.
// Without it, port 1 (data) wins every tie.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r0_req,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  output logic                  r0_ack,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  input  logic                  r1_req,
  input  logic                  r1_we,
  input  logic [2:0]            r1_addr_mode,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_ack,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [2:0]            mem_addr_mode,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  // Access-size code for a full word; instruction fetches always use it.
  localparam logic [2:0] DATA_ADDR_MODE_W = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t                state_q;
  logic                  grant_q;
  logic                  grant_d;
  logic                  memReq_q;
  logic                  memWe_q;
  logic [2:0]            memMode_q;
  logic [ADDR_WIDTH-1:0] memAddr_q;
  logic [DATA_WIDTH-1:0] memWdata_q;
  logic                  r0Ack_q;
  logic                  r1Ack_q;
  logic [DATA_WIDTH-1:0] r0Rdata_q;
  logic [DATA_WIDTH-1:0] r1Rdata_q;
  logic                  busy_q;
`ifdef MEM_ARB_RR_EN
  logic                  lastGrant_q;
`endif

  // Choose the winner among pending requests (1 = port 1); it is used only in IDLE.
  always_comb begin
    grant_d = r1_req;
    if (r0_req && r1_req) begin
`ifdef MEM_ARB_RR_EN
      grant_d = ~lastGrant_q;
`else
      grant_d = 1'b1;
`endif
    end
  end

  // Transaction FSM: latch winner, wait for memory, pulse the winner's ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      memReq_q   <= 1'b0;
      memWe_q    <= 1'b0;
      memMode_q  <= 3'b000;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      r0Ack_q    <= 1'b0;
      r1Ack_q    <= 1'b0;
      r0Rdata_q  <= '0;
      r1Rdata_q  <= '0;
      busy_q     <= 1'b0;
`ifdef MEM_ARB_RR_EN
      lastGrant_q <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (r0_req || r1_req) begin
            state_q  <= ACCESS;
            grant_q  <= grant_d;
            memReq_q <= 1'b1;
            busy_q   <= 1'b1;
            if (grant_d) begin
              memWe_q    <= r1_we;
              memMode_q  <= r1_addr_mode;
              memAddr_q  <= r1_addr;
              memWdata_q <= r1_wdata;
            end else begin
              memWe_q    <= 1'b0;
              memMode_q  <= DATA_ADDR_MODE_W;
              memAddr_q  <= r0_addr;
              memWdata_q <= '0;
            end
`ifdef MEM_ARB_RR_EN
            lastGrant_q <= grant_d;
`endif
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            state_q  <= RESP;
            memReq_q <= 1'b0;
            if (grant_q) begin
              r1Ack_q   <= 1'b1;
              r1Rdata_q <= memWe_q ? '0 : mem_rdata;
            end else begin
              r0Ack_q   <= 1'b1;
              r0Rdata_q <= memWe_q ? '0 : mem_rdata;
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
          r0Ack_q <= 1'b0;
          r1Ack_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign r0_ack        = r0Ack_q;
  assign r0_rdata      = r0Rdata_q;
  assign r1_ack        = r1Ack_q;
  assign r1_rdata      = r1Rdata_q;
  assign mem_req       = memReq_q;
  assign mem_we        = memWe_q;
  assign mem_addr_mode = memMode_q;
  assign mem_addr      = memAddr_q;
  assign mem_wdata     = memWdata_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized transactions for
// mem_arbiter. The reference model decides the winner, the memory-side
// fields and the returned data from the arbitration rules.
// Honours MEM_ARB_RR_EN the same way as the design.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [2:0] MODE_B = 3'b000;
  localparam logic [2:0] MODE_W = 3'b010;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          r0_req = 1'b0;
  logic [AW-1:0] r0_addr = '0;
  logic          r0_ack;
  logic [DW-1:0] r0_rdata;
  logic          r1_req = 1'b0;
  logic          r1_we = 1'b0;
  logic [2:0]    r1_addr_mode = 3'b000;
  logic [AW-1:0] r1_addr = '0;
  logic [DW-1:0] r1_wdata = '0;
  logic          r1_ack;
  logic [DW-1:0] r1_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [2:0]    mem_addr_mode;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: data each port last received, and the port granted most recently.
  logic [DW-1:0] modelRdata0 = '0;
  logic [DW-1:0] modelRdata1 = '0;
  int            modelLast = 1;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_addr(r0_addr), .r0_ack(r0_ack), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr_mode(r1_addr_mode), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_ack(r1_ack), .r1_rdata(r1_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_mode(mem_addr_mode), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Port that wins under the arbitration rules, given which ports request.
  function automatic int expectWinner(input logic q0, input logic q1);
    if (q0 && !q1) return 0;
    if (q1 && !q0) return 1;
`ifdef MEM_ARB_RR_EN
    return 1 - modelLast;
`else
    return 1;
`endif
  endfunction

  // Memory side: hold ready low for waitCycles, then complete with data; returns in RESP.
  task automatic memRespond(input int waitCycles, input logic [DW-1:0] data);
    for (int i = 0; i < waitCycles; i++) begin
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      @(negedge clk);
    end
    mem_ready = 1'b1;
    mem_rdata = data;
    @(negedge clk);
    mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({mem_req, mem_we, busy, r0_ack, r1_ack} !== 5'b00000) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl got %b exp %b", {mem_req, mem_we, busy, r0_ack, r1_ack}, 5'b00000);
    end
    vectors++;
    if ({mem_addr_mode, mem_addr, mem_wdata} !== {3'b000, 32'h0, 32'h0}) begin
      miscompares++;
      $display("[TB] FAIL reset_mem got %h exp 0", {mem_addr_mode, mem_addr, mem_wdata});
    end
    vectors++;
    if ({r0_rdata, r1_rdata} !== 64'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_rdata got %h exp 0", {r0_rdata, r1_rdata});
    end
    rst = 1'b0;
    mem_ready = 1'b0;
    modelRdata0 = '0;
    modelRdata1 = '0;
    modelLast = 1;
  endtask

  task automatic test_single_read();
    r0_req = 1'b1;
    r0_addr = 32'h100;
    @(negedge clk);
    vectors++;
    if ({mem_req, busy, mem_we, mem_addr_mode, mem_addr, mem_wdata} !== {2'b11, 1'b0, MODE_W, 32'h100, 32'h0}) begin
      miscompares++;
      $display("[TB] FAIL read_mem got %h exp %h", {mem_req, busy, mem_we, mem_addr_mode, mem_addr, mem_wdata},
               {2'b11, 1'b0, MODE_W, 32'h100, 32'h0});
    end
    memRespond(3, 32'hDEADBEEF);
    r0_req = 1'b0;
    modelRdata0 = 32'hDEADBEEF;
    modelLast = 0;
    vectors++;
    if ({r0_ack, r1_ack, mem_req, busy, r0_rdata} !== {4'b1001, modelRdata0}) begin
      miscompares++;
      $display("[TB] FAIL read_ack got %h exp %h", {r0_ack, r1_ack, mem_req, busy, r0_rdata}, {4'b1001, modelRdata0});
    end
    @(negedge clk);
    vectors++;
    if ({r0_ack, r1_ack, mem_req, busy, r0_rdata} !== {4'b0000, modelRdata0}) begin
      miscompares++;
      $display("[TB] FAIL read_after got %h exp %h", {r0_ack, r1_ack, mem_req, busy, r0_rdata}, {4'b0000, modelRdata0});
    end
  endtask

  task automatic test_byte_write();
    r1_req = 1'b1;
    r1_we = 1'b1;
    r1_addr_mode = MODE_B;
    r1_addr = 32'h23;
    r1_wdata = 32'hAB;
    @(negedge clk);
    vectors++;
    if ({mem_req, mem_we, mem_addr_mode, mem_addr, mem_wdata} !== {2'b11, MODE_B, 32'h23, 32'hAB}) begin
      miscompares++;
      $display("[TB] FAIL write_mem got %h exp %h", {mem_req, mem_we, mem_addr_mode, mem_addr, mem_wdata},
               {2'b11, MODE_B, 32'h23, 32'hAB});
    end
    memRespond(0, 32'h5A5A1234);
    r1_req = 1'b0;
    modelRdata1 = '0;
    modelLast = 1;
    vectors++;
    if ({r1_ack, r0_ack, r1_rdata, r0_rdata} !== {2'b10, modelRdata1, modelRdata0}) begin
      miscompares++;
      $display("[TB] FAIL write_ack got %h exp %h", {r1_ack, r0_ack, r1_rdata, r0_rdata}, {2'b10, modelRdata1, modelRdata0});
    end
    @(negedge clk);
    vectors++;
    if ({busy, r1_ack} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL write_after got %b exp 00", {busy, r1_ack});
    end
  endtask

  task automatic test_tie_rounds();
    int win;
    logic [DW-1:0] data;
    r0_req = 1'b1;
    r0_addr = 32'h200;
    r1_req = 1'b1;
    r1_we = 1'b0;
    r1_addr_mode = MODE_W;
    r1_addr = 32'h300;
    r1_wdata = 32'hFFFF0000;
    for (int round = 0; round < 4; round++) begin
      win = expectWinner(1'b1, 1'b1);
      data = $urandom;
      @(negedge clk);
      vectors++;
      if (mem_addr !== ((win == 1) ? 32'h300 : 32'h200)) begin
        miscompares++;
        $display("[TB] FAIL tie_addr round %0d got %h exp port %0d", round, mem_addr, win);
      end
      memRespond(round % 2, data);
      if (win == 0) modelRdata0 = data;
      else modelRdata1 = data;
      modelLast = win;
      vectors++;
      if ({r0_ack, r1_ack, r0_rdata, r1_rdata} !== {(win == 0), (win == 1), modelRdata0, modelRdata1}) begin
        miscompares++;
        $display("[TB] FAIL tie_grant round %0d got acks %b%b exp port %0d", round, r0_ack, r1_ack, win);
      end
      @(negedge clk);
      vectors++;
      if ({busy, r0_ack, r1_ack} !== 3'b000) begin
        miscompares++;
        $display("[TB] FAIL tie_idle round %0d got %b exp 000", round, {busy, r0_ack, r1_ack});
      end
    end
    r0_req = 1'b0;
    r1_req = 1'b0;
  endtask

  task automatic test_input_change();
    logic [DW-1:0] data;
    r1_req = 1'b1;
    r1_we = 1'b0;
    r1_addr_mode = MODE_W;
    r1_addr = 32'h40;
    r1_wdata = 32'h1111;
    @(negedge clk);
    vectors++;
    if (mem_addr !== 32'h40) begin
      miscompares++;
      $display("[TB] FAIL change_first got %h exp 00000040", mem_addr);
    end
    r1_addr = 32'h80;
    r1_we = 1'b1;
    r1_addr_mode = MODE_B;
    r1_wdata = 32'h2222;
    mem_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if ({mem_addr, mem_we, mem_addr_mode, mem_wdata} !== {32'h40, 1'b0, MODE_W, 32'h1111}) begin
      miscompares++;
      $display("[TB] FAIL change_hold got %h exp %h", {mem_addr, mem_we, mem_addr_mode, mem_wdata}, {32'h40, 1'b0, MODE_W, 32'h1111});
    end
    data = $urandom;
    memRespond(1, data);
    r1_req = 1'b0;
    modelRdata1 = data;
    modelLast = 1;
    vectors++;
    if ({r1_ack, r1_rdata, mem_addr} !== {1'b1, modelRdata1, 32'h40}) begin
      miscompares++;
      $display("[TB] FAIL change_ack got %h exp %h", {r1_ack, r1_rdata, mem_addr}, {1'b1, modelRdata1, 32'h40});
    end
    @(negedge clk);
  endtask

  task automatic test_spurious_ready();
    r0_req = 1'b0;
    r1_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b1;
      mem_rdata = 32'hCAFEF00D;
      @(negedge clk);
      vectors++;
      if ({mem_req, busy, r0_ack, r1_ack, r0_rdata, r1_rdata} !== {4'b0000, modelRdata0, modelRdata1}) begin
        miscompares++;
        $display("[TB] FAIL spurious cycle %0d got %h exp %h", i, {mem_req, busy, r0_ack, r1_ack, r0_rdata, r1_rdata},
                 {4'b0000, modelRdata0, modelRdata1});
      end
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_reset_in_access();
    int win;
    logic [DW-1:0] data;
    r0_req = 1'b1;
    r0_addr = 32'h500;
    @(negedge clk);
    vectors++;
    if ({mem_req, busy} !== 2'b11) begin
      miscompares++;
      $display("[TB] FAIL rstacc_start got %b exp 11", {mem_req, busy});
    end
    mem_ready = 1'b0;
    rst = 1'b1;
    r0_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    modelRdata0 = '0;
    modelRdata1 = '0;
    modelLast = 1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({mem_req, busy, r0_ack, r1_ack, r0_rdata, r1_rdata} !== {4'b0000, 64'h0}) begin
        miscompares++;
        $display("[TB] FAIL rstacc_quiet cycle %0d got %h exp 0", i, {mem_req, busy, r0_ack, r1_ack, r0_rdata, r1_rdata});
      end
      mem_ready = 1'b1;
      mem_rdata = $urandom;
      @(negedge clk);
    end
    mem_ready = 1'b0;
    r0_req = 1'b1;
    r0_addr = 32'h600;
    r1_req = 1'b1;
    r1_we = 1'b0;
    r1_addr_mode = MODE_W;
    r1_addr = 32'h700;
    win = expectWinner(1'b1, 1'b1);
    data = $urandom;
    @(negedge clk);
    r0_req = 1'b0;
    r1_req = 1'b0;
    vectors++;
    if (mem_addr !== ((win == 1) ? 32'h700 : 32'h600)) begin
      miscompares++;
      $display("[TB] FAIL rst_first_tie got %h exp port %0d", mem_addr, win);
    end
    memRespond(0, data);
    if (win == 0) modelRdata0 = data;
    else modelRdata1 = data;
    modelLast = win;
    vectors++;
    if ({r0_ack, r1_ack, r0_rdata, r1_rdata} !== {(win == 0), (win == 1), modelRdata0, modelRdata1}) begin
      miscompares++;
      $display("[TB] FAIL rst_tie_ack got acks %b%b exp port %0d", r0_ack, r1_ack, win);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int win;
    int lat;
    logic [1:0] pat;
    logic [DW-1:0] data;
    logic [AW-1:0] expAddr;
    logic [DW-1:0] expWdata;
    logic expWe;
    logic [2:0] expMode;
    for (int t = 0; t < 24; t++) begin
      pat = 2'($urandom_range(1, 3));
      lat = $urandom_range(0, 3);
      data = $urandom;
      r0_req = pat[0];
      r1_req = pat[1];
      r0_addr = $urandom;
      r1_addr = $urandom;
      r1_we = 1'($urandom);
      r1_addr_mode = 3'($urandom);
      r1_wdata = $urandom;
      win = expectWinner(pat[0], pat[1]);
      if (win == 1) begin
        expAddr = r1_addr;
        expWe = r1_we;
        expMode = r1_addr_mode;
        expWdata = r1_wdata;
      end else begin
        expAddr = r0_addr;
        expWe = 1'b0;
        expMode = MODE_W;
        expWdata = '0;
      end
      @(negedge clk);
      vectors++;
      if ({mem_req, busy, mem_we, mem_addr_mode, mem_addr, mem_wdata} !== {2'b11, expWe, expMode, expAddr, expWdata}) begin
        miscompares++;
        $display("[TB] FAIL rand_mem txn %0d got %h exp %h", t, {mem_req, busy, mem_we, mem_addr_mode, mem_addr, mem_wdata},
                 {2'b11, expWe, expMode, expAddr, expWdata});
      end
      r0_addr = $urandom;
      r1_addr = $urandom;
      r1_wdata = $urandom;
      memRespond(lat, data);
      if (win == 0) modelRdata0 = data;
      else modelRdata1 = expWe ? '0 : data;
      modelLast = win;
      vectors++;
      if ({r0_ack, r1_ack, mem_req, mem_addr} !== {(win == 0), (win == 1), 1'b0, expAddr}) begin
        miscompares++;
        $display("[TB] FAIL rand_ack txn %0d got %h exp port %0d", t, {r0_ack, r1_ack, mem_req, mem_addr}, win);
      end
      vectors++;
      if ({r0_rdata, r1_rdata} !== {modelRdata0, modelRdata1}) begin
        miscompares++;
        $display("[TB] FAIL rand_rdata txn %0d got %h exp %h", t, {r0_rdata, r1_rdata}, {modelRdata0, modelRdata1});
      end
      r0_req = 1'b0;
      r1_req = 1'b0;
      @(negedge clk);
      vectors++;
      if ({busy, r0_ack, r1_ack} !== 3'b000) begin
        miscompares++;
        $display("[TB] FAIL rand_idle txn %0d got %b exp 000", t, {busy, r0_ack, r1_ack});
      end
    end
  endtask

  // Scenario sequence followed by the one-line summary.
  initial begin
    test_reset();
    test_single_read();
    test_byte_write();
    test_tie_rounds();
    test_input_change();
    test_spurious_ready();
    test_reset_in_access();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
